// File: rtl/gr_mem_wr_arbiter.sv
// Round-robin arbiter feeding BL-word bursts from two FWFT FIFOs to one memory write port; cmd one cycle after grant.
// Stalls on cmd_rdy / wr_data_rdy; a granted burst always runs to completion; FIFO pops follow wr_data_rdy.
module gr_mem_wr_arbiter #(
    parameter int BL = 16,
    parameter int AW = 22,
    parameter int DW = 36,
    parameter int LW = 16
) (
    input  logic          rd_clk,
    input  logic          rd_rst_n,
    input  logic          enable,
    input  logic [AW-1:0] cfg_base0,
    input  logic [AW-1:0] cfg_base1,
    input  logic [LW-1:0] cfg_len0,
    input  logic [LW-1:0] cfg_len1,
    input  logic          restart0,
    input  logic          restart1,
    input  logic          burst_avail0,
    input  logic          burst_avail1,
    output logic          burst_rd_en0,
    output logic          burst_rd_en1,
    input  logic [DW-1:0] burst_rd_data0,
    input  logic [DW-1:0] burst_rd_data1,
    output logic          cmd_en,
    output logic [AW-1:0] cmd_addr,
    input  logic          cmd_rdy,
    output logic          wr_data_en,
    output logic [DW-1:0] wr_data,
    input  logic          wr_data_rdy,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          err_len
);

    localparam int CW = (BL > 1) ? $clog2(BL) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, NEXT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          prio_q, prio_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q [2];
    logic [AW-1:0] addr_d [2];
    logic [LW-1:0] idx_q [2];
    logic [LW-1:0] idx_d [2];
    logic [1:0]    pend_q, pend_d;

    logic [AW-1:0] base [2];
    logic [LW-1:0] len_eff [2];
    logic [1:0]    restart;
    logic          req, pick1, avail_g, last_word;

    assign base[0]    = cfg_base0;
    assign base[1]    = cfg_base1;
    assign len_eff[0] = (cfg_len0 == '0) ? LW'(1) : cfg_len0;
    assign len_eff[1] = (cfg_len1 == '0) ? LW'(1) : cfg_len1;
    assign restart    = {restart1, restart0};

    assign req       = enable & (burst_avail0 | burst_avail1);
    assign pick1     = (burst_avail0 & burst_avail1) ? prio_q : burst_avail1;
    assign avail_g   = grant_q[1] ? burst_avail1 : burst_avail0;
    assign last_word = (cnt_q == CW'(BL - 1));

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = CMD;
            CMD:     if (cmd_rdy) state_d = DATA;
            DATA:    if (wr_data_rdy && last_word) state_d = NEXT;
            NEXT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d    = grant_q;
        prio_d     = prio_q;
        cmd_addr_d = cmd_addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pend_d     = pend_q;
        for (int p = 0; p < 2; p++) begin
            addr_d[p] = addr_q[p];
            idx_d[p]  = idx_q[p];
            // A granted port defers its reload to NEXT so the running burst keeps its address
            if (restart[p]) begin
                if (grant_q[p]) begin
                    pend_d[p] = 1'b1;
                end else begin
                    addr_d[p] = base[p];
                    idx_d[p]  = '0;
                end
            end
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    if (pick1) cmd_addr_d = restart[1] ? base[1] : addr_q[1];
                    else       cmd_addr_d = restart[0] ? base[0] : addr_q[0];
                end
            end
            DATA: begin
                if (wr_data_rdy) cnt_d = cnt_q + CW'(1);
                if (!avail_g && !last_word) err_d = 1'b1;
            end
            NEXT: begin
                for (int p = 0; p < 2; p++) begin
                    if (grant_q[p]) begin
                        pend_d[p] = 1'b0;
                        if (pend_q[p] || restart[p] || (idx_q[p] + LW'(1) == len_eff[p])) begin
                            addr_d[p] = base[p];
                            idx_d[p]  = '0;
                        end else begin
                            addr_d[p] = addr_q[p] + AW'(BL);
                            idx_d[p]  = idx_q[p] + LW'(1);
                        end
                    end
                end
                prio_d  = grant_q[0];
                grant_d = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            grant_q    <= '0;
            prio_q     <= 1'b0;
            cmd_addr_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            pend_q     <= '0;
            for (int p = 0; p < 2; p++) begin
                addr_q[p] <= base[p];
                idx_q[p]  <= '0;
            end
        end else begin
            grant_q    <= grant_d;
            prio_q     <= prio_d;
            cmd_addr_q <= cmd_addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            for (int p = 0; p < 2; p++) begin
                addr_q[p] <= addr_d[p];
                idx_q[p]  <= idx_d[p];
            end
        end
    end

    always_comb begin
        cmd_en       = (state_q == CMD);
        cmd_addr     = cmd_addr_q;
        wr_data_en   = (state_q == DATA);
        wr_data      = '0;
        burst_rd_en0 = 1'b0;
        burst_rd_en1 = 1'b0;
        if (state_q == DATA) begin
            wr_data      = grant_q[1] ? burst_rd_data1 : burst_rd_data0;
            burst_rd_en0 = grant_q[0] & wr_data_rdy;
            burst_rd_en1 = grant_q[1] & wr_data_rdy;
        end
        grant   = grant_q;
        busy    = (state_q != IDLE);
        err_len = err_q;
    end

endmodule
